// File: rtl/if_id_stage.sv
// PC register, IF/ID pipeline register and ID-stage branch/jump resolution.
// A taken transfer seen while the I-cache is stalled parks its target until fetch can resume.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ICache_stall,
  input  logic        DCache_stall,
  input  logic        stallLU,
  input  logic        stallJ,
  input  logic [1:0]  ForwardJA,
  input  logic [1:0]  ForwardJB,
  input  logic [31:0] IF_instr,
  input  logic [31:0] ID_RsData,
  input  logic [31:0] ID_RtData,
  input  logic [31:0] EXMEM_ALUout,
  output logic [31:0] IF_PC,
  output logic        ICache_read,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_PCplus4,
  output logic [4:0]  ID_RegJump,
  output logic [4:0]  ID_RegRt,
  output logic        ID_Branch,
  output logic        ID_JumpR,
  output logic        ID_redirect
);

  typedef enum logic {S_RUN, S_REDIR_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [31:0] r_ifid_pc4, w_ifid_pc4_nxt;
  logic [31:0] r_redir_tgt, w_redir_tgt_nxt;

  logic [5:0]  w_op, w_funct;
  logic        w_is_beq, w_is_bne, w_is_jimm, w_is_jreg;
  logic [31:0] w_opa, w_opb, w_br_off, w_target;
  logic        w_taken, w_accept;

  assign w_op      = r_ifid_instr[31:26];
  assign w_funct   = r_ifid_instr[5:0];
  assign w_is_beq  = (w_op == 6'b000100);
  assign w_is_bne  = (w_op == 6'b000101);
  assign w_is_jimm = (w_op == 6'b000010) || (w_op == 6'b000011);
  assign w_is_jreg = (w_op == 6'b000000) &&
                     ((w_funct == 6'b001000) || (w_funct == 6'b001001));

  // Only encoding 01 forwards; 10/11 fall back to the register file
  assign w_opa = (ForwardJA == 2'b01) ? EXMEM_ALUout : ID_RsData;
  assign w_opb = (ForwardJB == 2'b01) ? EXMEM_ALUout : ID_RtData;

  assign w_br_off = {{14{r_ifid_instr[15]}}, r_ifid_instr[15:0], 2'b00};
  assign w_taken  = (w_is_beq && (w_opa == w_opb)) ||
                    (w_is_bne && (w_opa != w_opb)) ||
                    w_is_jimm || w_is_jreg;

  always_comb begin
    w_target = r_ifid_pc4 + w_br_off;
    if (w_is_jimm)
      w_target = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
    else if (w_is_jreg)
      w_target = w_opa;
  end

  assign w_accept = !rst && (r_state == S_RUN) && w_taken &&
                    !DCache_stall && !stallLU && !stallJ;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_redir_tgt_nxt  = r_redir_tgt;
    if (DCache_stall) begin
      w_state_nxt = r_state;
    end else if (r_state == S_REDIR_WAIT) begin
      if (!ICache_stall) begin
        w_pc_nxt         = r_redir_tgt;
        w_ifid_instr_nxt = 32'h0;
        w_ifid_pc4_nxt   = 32'h0;
        w_state_nxt      = S_RUN;
      end
    end else if (stallLU || stallJ) begin
      w_state_nxt = r_state;
    end else if (w_taken) begin
      w_ifid_instr_nxt = 32'h0;
      w_ifid_pc4_nxt   = 32'h0;
      if (ICache_stall) begin
        w_redir_tgt_nxt = w_target;
        w_state_nxt     = S_REDIR_WAIT;
      end else begin
        w_pc_nxt = w_target;
      end
    end else if (ICache_stall) begin
      w_ifid_instr_nxt = 32'h0;
      w_ifid_pc4_nxt   = 32'h0;
    end else begin
      w_pc_nxt         = r_pc + 32'd4;
      w_ifid_instr_nxt = IF_instr;
      w_ifid_pc4_nxt   = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'h0;
      r_ifid_pc4   <= 32'h0;
      r_redir_tgt  <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_redir_tgt  <= w_redir_tgt_nxt;
    end
  end

  assign IF_PC        = r_pc;
  assign ICache_read  = !rst;
  assign IFID_instr   = r_ifid_instr;
  assign IFID_PCplus4 = r_ifid_pc4;
  assign ID_RegJump   = r_ifid_instr[25:21];
  assign ID_RegRt     = r_ifid_instr[20:16];
  assign ID_Branch    = !rst && (w_is_beq || w_is_bne);
  assign ID_JumpR     = !rst && w_is_jreg;
  assign ID_redirect  = w_accept;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed vector table for if_id_stage followed by random stimulus checked against
// an instruction-level reference model of fetch/redirect behaviour.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, ICache_stall, DCache_stall, stallLU, stallJ;
  logic [1:0]  ForwardJA, ForwardJB;
  logic [31:0] IF_instr, ID_RsData, ID_RtData, EXMEM_ALUout;
  logic [31:0] IF_PC, IFID_instr, IFID_PCplus4;
  logic        ICache_read, ID_Branch, ID_JumpR, ID_redirect;
  logic [4:0]  ID_RegJump, ID_RegRt;

  int n_pass = 0;
  int n_total = 0;

  if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
    .stallLU(stallLU), .stallJ(stallJ), .ForwardJA(ForwardJA), .ForwardJB(ForwardJB),
    .IF_instr(IF_instr), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
    .EXMEM_ALUout(EXMEM_ALUout), .IF_PC(IF_PC), .ICache_read(ICache_read),
    .IFID_instr(IFID_instr), .IFID_PCplus4(IFID_PCplus4), .ID_RegJump(ID_RegJump),
    .ID_RegRt(ID_RegRt), .ID_Branch(ID_Branch), .ID_JumpR(ID_JumpR),
    .ID_redirect(ID_redirect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst, ics, dcs, slu, sj;
    logic [1:0]  fja;
    logic [31:0] instr, rs, rt, ex;
    logic        redir;
    logic [31:0] pc, ifid, pc4;
    logic        ck4;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic r, ics, dcs, slu, sj, input logic [1:0] fja,
                      input logic [31:0] instr, rs, rt, ex, input logic redir,
                      input logic [31:0] pc, ifid, pc4, input logic ck4);
    vec_t v;
    v.rst = r; v.ics = ics; v.dcs = dcs; v.slu = slu; v.sj = sj; v.fja = fja;
    v.instr = instr; v.rs = rs; v.rt = rt; v.ex = ex; v.redir = redir;
    v.pc = pc; v.ifid = ifid; v.pc4 = pc4; v.ck4 = ck4;
    tbl.push_back(v);
  endtask

  localparam logic [31:0] I1   = 32'h2001_0001;
  localparam logic [31:0] I2   = 32'h2002_0002;
  localparam logic [31:0] I3   = 32'h2003_0003;
  localparam logic [31:0] BEQ  = 32'h1000_FFFE;
  localparam logic [31:0] BNE  = 32'h1400_FFFE;
  localparam logic [31:0] JR   = 32'h0020_0008;
  localparam logic [31:0] JAL  = 32'h0C12_3456;
  localparam logic [31:0] JMP  = 32'h0800_0100;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  // Reference model: architectural view of the stage
  logic [31:0] m_pc, m_instr, m_pc4, m_tgt;
  logic        m_wait, m_pc4_known;

  function automatic logic [31:0] opsel(input logic [1:0] f, input logic [31:0] reg_v,
                                        input logic [31:0] fwd);
    return (f == 2'b01) ? fwd : reg_v;
  endfunction

  task automatic resolve(input logic [31:0] ins, pc4, a, b,
                         output logic taken, output logic [31:0] tgt);
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    taken = 1'b0;
    tgt = 32'h0;
    if (op == 4 || op == 5) begin
      taken = (op == 4) ? (a == b) : (a != b);
      tgt = pc4 + 32'($signed(ins[15:0]) * 4);
    end else if (op == 2 || op == 3) begin
      taken = 1'b1;
      tgt = {pc4[31:28], ins[25:0], 2'b00};
    end else if (op == 0 && (fn == 8 || fn == 9)) begin
      taken = 1'b1;
      tgt = a;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return {6'd4, r[25:0]};
      1: return {6'd5, r[25:0]};
      2: return {6'd2, r[25:0]};
      3: return {6'd3, r[25:0]};
      4: return {6'd0, r[25:6], 6'd8};
      5: return {6'd0, r[25:6], 6'd9};
      default: return {6'd8, r[25:0]};
    endcase
  endfunction

  initial begin
    logic taken, exp_redir, is_br, is_jr;
    logic [31:0] tgt, a, b, r32;
    rst = 1'b1; ICache_stall = 0; DCache_stall = 0; stallLU = 0; stallJ = 0;
    ForwardJA = 0; ForwardJB = 0; IF_instr = 0; ID_RsData = 0; ID_RtData = 0;
    EXMEM_ALUout = 0;

    //   rst ics dcs slu sj fja instr rs  rt  ex   redir pc  ifid pc4 ck4
    addv(1,0,0,0,0,0, JUNK, 0,0,0,           0, 32'h0,  0,    32'h0,  1);
    addv(0,0,0,0,0,0, I1,   0,0,0,           0, 32'h4,  I1,   32'h4,  1);
    addv(0,0,0,0,0,0, I2,   0,0,0,           0, 32'h8,  I2,   32'h8,  1);
    addv(0,0,0,0,0,0, I3,   0,0,0,           0, 32'hC,  I3,   32'hC,  1);
    addv(0,0,0,0,0,0, I1,   0,0,0,           0, 32'h10, I1,   32'h10, 1);
    addv(0,0,0,0,0,0, I2,   0,0,0,           0, 32'h14, I2,   32'h14, 1);
    addv(0,0,0,0,0,0, I3,   0,0,0,           0, 32'h18, I3,   32'h18, 1);
    addv(0,0,0,0,0,0, I1,   0,0,0,           0, 32'h1C, I1,   32'h1C, 1);
    addv(0,0,0,0,0,0, BEQ,  0,0,0,           0, 32'h20, BEQ,  32'h20, 1);
    addv(0,0,0,0,0,0, JUNK, 5,5,0,           1, 32'h18, 0,    0,      0);
    addv(0,0,0,0,0,0, BNE,  0,0,0,           0, 32'h1C, BNE,  32'h1C, 1);
    addv(0,0,0,0,0,0, JR,   7,7,0,           0, 32'h20, JR,   32'h20, 1);
    addv(0,0,0,0,0,1, JUNK, 32'h100,0,32'h400, 1, 32'h400, 0, 0,      0);
    addv(0,0,0,0,0,0, JR,   0,0,0,           0, 32'h404, JR,  32'h404, 1);
    addv(0,0,0,0,0,2, JUNK, 32'h100,0,32'h400, 1, 32'h100, 0, 0,      0);
    addv(0,0,0,0,0,0, JAL,  0,0,0,           0, 32'h104, JAL, 32'h104, 1);
    addv(0,0,0,0,1,0, JUNK, 0,0,0,           0, 32'h104, JAL, 32'h104, 1);
    addv(0,0,0,0,1,0, JUNK, 0,0,0,           0, 32'h104, JAL, 32'h104, 1);
    addv(0,0,0,0,0,0, JUNK, 0,0,0,           1, 32'h0048_D158, 0, 0,  0);
    addv(0,0,0,0,0,0, JMP,  0,0,0,           0, 32'h0048_D15C, JMP, 32'h0048_D15C, 1);
    addv(0,1,0,0,0,0, JUNK, 0,0,0,           1, 32'h0048_D15C, 0, 0,  0);
    addv(0,1,0,0,0,0, JUNK, 0,0,0,           0, 32'h0048_D15C, 0, 0,  0);
    addv(0,1,0,0,0,0, JUNK, 0,0,0,           0, 32'h0048_D15C, 0, 0,  0);
    addv(0,0,0,0,0,0, JUNK, 0,0,0,           0, 32'h400, 0,   0,      0);
    addv(0,0,0,0,0,0, JMP,  0,0,0,           0, 32'h404, JMP, 32'h404, 1);
    addv(0,1,0,0,0,0, JUNK, 0,0,0,           1, 32'h404, 0,   0,      0);
    addv(0,0,1,0,0,0, JUNK, 0,0,0,           0, 32'h404, 0,   0,      0);
    addv(0,0,1,0,0,0, JUNK, 0,0,0,           0, 32'h404, 0,   0,      0);
    addv(1,0,1,0,0,0, JUNK, 0,0,0,           0, 32'h0,   0,   32'h0,  1);
    addv(0,0,0,0,0,0, I1,   0,0,0,           0, 32'h4,   I1,  32'h4,  1);
    addv(0,0,0,1,0,0, JUNK, 0,0,0,           0, 32'h4,   I1,  32'h4,  1);
    addv(0,1,0,0,0,0, JUNK, 0,0,0,           0, 32'h4,   0,   32'h0,  1);
    addv(0,0,0,0,0,0, BEQ,  0,0,0,           0, 32'h8,   BEQ, 32'h8,  1);
    addv(0,0,1,0,0,0, JUNK, 1,1,0,           0, 32'h8,   BEQ, 32'h8,  1);
    addv(0,0,0,1,0,0, JUNK, 1,1,0,           0, 32'h8,   BEQ, 32'h8,  1);
    addv(0,0,0,0,0,0, I2,   1,2,0,           0, 32'hC,   I2,  32'hC,  1);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; ICache_stall = tbl[i].ics; DCache_stall = tbl[i].dcs;
      stallLU = tbl[i].slu; stallJ = tbl[i].sj; ForwardJA = tbl[i].fja; ForwardJB = 2'b00;
      IF_instr = tbl[i].instr; ID_RsData = tbl[i].rs; ID_RtData = tbl[i].rt;
      EXMEM_ALUout = tbl[i].ex;
      #1;
      chk($sformatf("vec%0d redirect", i), 32'(ID_redirect), 32'(tbl[i].redir));
      chk($sformatf("vec%0d icache_read", i), 32'(ICache_read), 32'(!tbl[i].rst));
      if (i == 12) begin
        chk("vec12 regjump", 32'(ID_RegJump), 32'd1);
        chk("vec12 jumpr", 32'(ID_JumpR), 32'd1);
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pc", i), IF_PC, tbl[i].pc);
      chk($sformatf("vec%0d ifid_instr", i), IFID_instr, tbl[i].ifid);
      if (tbl[i].ck4) chk($sformatf("vec%0d ifid_pc4", i), IFID_PCplus4, tbl[i].pc4);
    end

    m_pc = 0; m_instr = 0; m_pc4 = 0; m_tgt = 0; m_wait = 0; m_pc4_known = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = (c == 0) || ($urandom_range(0, 99) == 0);
      ICache_stall = ($urandom_range(0, 3) == 0);
      DCache_stall = ($urandom_range(0, 9) == 0);
      stallLU = ($urandom_range(0, 9) == 0);
      stallJ = ($urandom_range(0, 9) == 0);
      ForwardJA = 2'($urandom_range(0, 3));
      ForwardJB = 2'($urandom_range(0, 3));
      IF_instr = rand_instr();
      r32 = $urandom;
      ID_RsData = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : r32;
      ID_RtData = ($urandom_range(0, 1) == 0) ? r32 : $urandom;
      EXMEM_ALUout = ($urandom_range(0, 1) == 0) ? r32 : $urandom;
      #1;
      if (c > 0) begin
        chk("rnd pc", IF_PC, m_pc);
        chk("rnd ifid_instr", IFID_instr, m_instr);
        if (m_pc4_known) chk("rnd ifid_pc4", IFID_PCplus4, m_pc4);
        chk("rnd regjump", 32'(ID_RegJump), 32'(m_instr[25:21]));
        chk("rnd regrt", 32'(ID_RegRt), 32'(m_instr[20:16]));
      end
      a = opsel(ForwardJA, ID_RsData, EXMEM_ALUout);
      b = opsel(ForwardJB, ID_RtData, EXMEM_ALUout);
      resolve(m_instr, m_pc4, a, b, taken, tgt);
      is_br = !rst && (m_instr[31:26] == 6'd4 || m_instr[31:26] == 6'd5);
      is_jr = !rst && m_instr[31:26] == 6'd0 && (m_instr[5:0] == 6'd8 || m_instr[5:0] == 6'd9);
      exp_redir = !rst && !m_wait && taken && !DCache_stall && !stallLU && !stallJ;
      if (c > 0) begin
        chk("rnd redirect", 32'(ID_redirect), 32'(exp_redir));
        chk("rnd branch", 32'(ID_Branch), 32'(is_br));
        chk("rnd jumpr", 32'(ID_JumpR), 32'(is_jr));
      end
      if (rst) begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_pc4_known = 1; m_wait = 0; m_tgt = 0;
      end else if (DCache_stall) begin
        m_wait = m_wait;
      end else if (m_wait) begin
        if (!ICache_stall) begin
          m_pc = m_tgt; m_instr = 0; m_pc4_known = 0; m_wait = 0;
        end
      end else if (stallLU || stallJ) begin
        m_wait = 1'b0;
      end else if (taken) begin
        m_instr = 0; m_pc4_known = 0;
        if (ICache_stall) begin
          m_tgt = tgt; m_wait = 1'b1;
        end else begin
          m_pc = tgt;
        end
      end else if (ICache_stall) begin
        m_instr = 0; m_pc4 = 0; m_pc4_known = 1;
      end else begin
        m_pc = m_pc + 4; m_instr = IF_instr; m_pc4 = m_pc; m_pc4_known = 1;
      end
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
